alarm_ring_ctrl: RTL and testbench
==================================

ALARM_RING_CTRL -- requirements
Module: alarm_ring_ctrl

Interface
REQ-001 SHALL have parameter RING_TIMEOUT_S, default 60, meaning seconds of ringing before auto-stop (range 1..511).
REQ-002 SHALL have parameter SNOOZE_S, default 300, meaning snooze length in seconds (range 1..511).
REQ-003 SHALL have parameter MAX_SNOOZE, default 3, meaning snoozes allowed per alarm event (used only under REQ-024).
REQ-004 Ports:
- clk  input  1: system clock; the only clock.
- reset  input  1: synchronous, active-high reset.
- tick_1hz  input  1: one-cycle-per-second enable pulse, in the clk domain.
- alarm_match  input  1: level, high while current time equals alarm time.
- alarm_en  input  1: alarm armed.
- flag_short  input  1: one-cycle short-press pulse, meaning snooze.
- flag_long  input  1: one-cycle long-press pulse, meaning stop.
- led_alarm  output  1: beep/LED drive.
- ringing  output  1: state is RING.
- snoozed  output  1: state is SNOOZE.
- remain_s  output  9: seconds left in the current RING or SNOOZE phase; 0 in IDLE.

Function
REQ-005 SHALL implement states IDLE, RING and SNOOZE; all outputs SHALL be registered.
REQ-006 SHALL register alarm_match into match_q each cycle; trig = alarm_match & ~match_q & alarm_en.
REQ-007 IDLE->RING on trig; ringing SHALL be high the cycle after the edge that sampled trig (1-cycle latency); remain_s SHALL load RING_TIMEOUT_S.
REQ-008 In RING, each tick_1hz SHALL decrement remain_s; the tick that takes remain_s from 1 to 0 SHALL go to IDLE (auto-stop).
REQ-009 RING->SNOOZE on flag_short; remain_s SHALL load SNOOZE_S.
REQ-010 RING->IDLE on flag_long.
REQ-011 In SNOOZE, each tick_1hz SHALL decrement remain_s; the tick from 1 to 0 SHALL go to RING and reload RING_TIMEOUT_S.
REQ-012 SNOOZE->IDLE on flag_long; flag_short in SNOOZE SHALL be ignored.
REQ-013 alarm_en low SHALL force IDLE on the next cycle from any state.
REQ-014 trig in RING or SNOOZE SHALL be ignored.
REQ-015 Same-cycle priority SHALL be: reset > alarm_en low > flag_long > flag_short > tick_1hz > trig; a button pulse in the same cycle as a tick SHALL win and the tick SHALL be discarded.
REQ-016 led_alarm SHALL be 1 on entry to RING and SHALL toggle on every tick_1hz while in RING (1 s on, 1 s off); it SHALL be 0 in IDLE and SNOOZE.
REQ-017 remain_s SHALL never underflow; in IDLE it SHALL be held at 0.

Reset
REQ-018 On reset, state SHALL be IDLE and ringing, snoozed, led_alarm and remain_s SHALL all be 0.
REQ-019 On reset, match_q SHALL reset to 1, so an alarm_match already high at reset release does not ring.
REQ-020 Reset asserted mid-RING or mid-SNOOZE SHALL abort the alarm event on the next clock edge.
REQ-021 On reset, the snooze counter SHALL clear to 0.

Configuration
REQ-022 Macro ALARM_SNOOZE_LIMIT_EN SHALL select snooze limiting.
REQ-023 Without the macro, snoozes SHALL be unlimited and no snooze counter SHALL exist.
REQ-024 With the macro:
- a 2-bit snooze_cnt SHALL increment on each RING->SNOOZE transition.
- snooze_cnt SHALL clear on entry to IDLE.
- when snooze_cnt equals MAX_SNOOZE, flag_short in RING SHALL act as flag_long (go to IDLE).

Structure
REQ-025 Package alarm_pkg SHALL hold the state enum, the remain_s width constant (9) and the default timeout constants.
REQ-026 Sub-module sec_down_counter (load, tick enable, 9-bit count, zero pulse) SHALL be used once, shared between the RING and SNOOZE phases.

Verification
REQ-027 Bench SHALL cover: alarm_en=1, alarm_match rising -> ringing=1 one cycle later, remain_s=60, led_alarm=1.
REQ-028 Bench SHALL cover: ring with no button for 60 ticks -> IDLE on the 60th tick, led_alarm toggled 59 times during the ring.
REQ-029 Bench SHALL cover: flag_short in RING -> snoozed=1, remain_s=300; after 300 ticks -> ringing=1, remain_s=60.
REQ-030 Bench SHALL cover: flag_long and flag_short in the same cycle during RING -> IDLE; flag_short and a tick in the same cycle -> SNOOZE with remain_s=300.
REQ-031 Bench SHALL cover: reset released with alarm_match=1 -> no ring; alarm_en dropped mid-SNOOZE -> IDLE next cycle, remain_s=0.
REQ-032 Bench SHALL cover, with ALARM_SNOOZE_LIMIT_EN: three snoozes, then a fourth flag_short -> IDLE.

Source files
------------

// File: rtl/alarm_pkg.sv
// Shared types and constants for the alarm ring controller: FSM state encoding,
// remaining-seconds width and default phase lengths.
package alarm_pkg;

    localparam int REMAIN_W         = 9;
    localparam int RING_TIMEOUT_DEF = 60;
    localparam int SNOOZE_DEF       = 300;
    localparam int MAX_SNOOZE_DEF   = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } state_e;

endpackage

// File: rtl/sec_down_counter.sv
// Seconds down-counter shared by the RING and SNOOZE phases; clear beats load,
// load beats tick, and the count saturates at zero.
module sec_down_counter
    import alarm_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                clear_i,
    input  logic                load_i,
    input  logic [REMAIN_W-1:0] load_val_i,
    input  logic                tick_i,
    output logic [REMAIN_W-1:0] count_o,
    output logic                zero_o
);

    logic [REMAIN_W-1:0] count_q, count_d;

    // NOTE: next-state logic gets its default first so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (tick_i && (count_q != '0)) begin
            count_d = count_q - REMAIN_W'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    // Marks the tick that takes the count from 1 to 0 (phase expiry)
    assign zero_o  = tick_i && (count_q == REMAIN_W'(1));

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Alarm ring/snooze controller with registered outputs. Define ALARM_SNOOZE_LIMIT_EN
// to cap snoozes per alarm event at MAX_SNOOZE; otherwise snoozes are unlimited.
module alarm_ring_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_TIMEOUT_S = RING_TIMEOUT_DEF,
    parameter int SNOOZE_S       = SNOOZE_DEF,
    parameter int MAX_SNOOZE     = MAX_SNOOZE_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick_1hz,
    input  logic                alarm_match,
    input  logic                alarm_en,
    input  logic                flag_short,
    input  logic                flag_long,
    output logic                led_alarm,
    output logic                ringing,
    output logic                snoozed,
    output logic [REMAIN_W-1:0] remain_s
);

    localparam logic [REMAIN_W-1:0] RING_LOAD   = REMAIN_W'(RING_TIMEOUT_S);
    localparam logic [REMAIN_W-1:0] SNOOZE_LOAD = REMAIN_W'(SNOOZE_S);

    if (RING_TIMEOUT_S < 1 || RING_TIMEOUT_S > 511 || SNOOZE_S < 1 || SNOOZE_S > 511 ||
        MAX_SNOOZE < 0 || MAX_SNOOZE > 3) begin : g_param_check
        $error("alarm_ring_ctrl: parameter out of range");
    end

    state_e              state_q, state_d;
    logic                match_q, trig, limit_hit;
    logic                led_q, led_d, ringing_q, snoozed_q;
    logic                cnt_clear, cnt_load, cnt_zero;
    logic [REMAIN_W-1:0] cnt_load_val, cnt_value;

    assign trig = alarm_match & ~match_q & alarm_en;

`ifdef ALARM_SNOOZE_LIMIT_EN
    localparam logic [1:0] MAX_SNOOZE_C = 2'(MAX_SNOOZE);
    logic [1:0] snooze_cnt_q;

    always_ff @(posedge clk) begin
        if (reset || state_d == ST_IDLE) begin
            snooze_cnt_q <= '0;
        end else if (state_q == ST_RING && state_d == ST_SNOOZE) begin
            snooze_cnt_q <= snooze_cnt_q + 2'd1;
        end
    end

    assign limit_hit = (snooze_cnt_q == MAX_SNOOZE_C);
`else
    assign limit_hit = 1'b0;
`endif

    // Button branches are checked before the tick, so a same-cycle tick is dropped
    always_comb begin
        state_d      = state_q;
        cnt_load     = 1'b0;
        cnt_load_val = RING_LOAD;
        led_d        = led_q;
        if (!alarm_en) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (trig) begin
                        state_d  = ST_RING;
                        cnt_load = 1'b1;
                    end
                end
                ST_RING: begin
                    if (flag_long) begin
                        state_d = ST_IDLE;
                    end else if (flag_short) begin
                        if (limit_hit) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d      = ST_SNOOZE;
                            cnt_load     = 1'b1;
                            cnt_load_val = SNOOZE_LOAD;
                        end
                    end else if (tick_1hz) begin
                        if (cnt_zero) begin
                            state_d = ST_IDLE;
                        end else begin
                            led_d = ~led_q;
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (flag_long) begin
                        state_d = ST_IDLE;
                    end else if (tick_1hz && cnt_zero) begin
                        state_d  = ST_RING;
                        cnt_load = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        cnt_clear = (state_d == ST_IDLE);
        if (state_d != ST_RING) begin
            led_d = 1'b0;
        end else if (state_q != ST_RING) begin
            led_d = 1'b1;
        end
    end

    sec_down_counter u_sec_cnt (
        .clk        (clk),
        .reset      (reset),
        .clear_i    (cnt_clear),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .tick_i     (tick_1hz),
        .count_o    (cnt_value),
        .zero_o     (cnt_zero)
    );

    // match_q resets high so a match already present at reset release cannot ring
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            match_q   <= 1'b1;
            led_q     <= 1'b0;
            ringing_q <= 1'b0;
            snoozed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            match_q   <= alarm_match;
            led_q     <= led_d;
            ringing_q <= (state_d == ST_RING);
            snoozed_q <= (state_d == ST_SNOOZE);
        end
    end

    assign led_alarm = led_q;
    assign ringing   = ringing_q;
    assign snoozed   = snoozed_q;
    assign remain_s  = cnt_value;

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Scoreboard bench for alarm_ring_ctrl at default parameters (60 s ring, 300 s snooze).
// Expected outputs are queued as stimulus is driven and compared per scenario.
module tb_alarm_ring_ctrl;
    import alarm_pkg::*;

    typedef struct packed {
        logic       ringing;
        logic       snoozed;
        logic       led;
        logic [8:0] remain;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset, tick_1hz, alarm_match, alarm_en, flag_short, flag_long;
    logic       led_alarm, ringing, snoozed;
    logic [8:0] remain_s;

    obs_t  exp_q[$];
    obs_t  obs_q[$];
    string name_q[$];
    int    n_checks = 0;
    int    n_pass   = 0;

    alarm_ring_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .tick_1hz    (tick_1hz),
        .alarm_match (alarm_match),
        .alarm_en    (alarm_en),
        .flag_short  (flag_short),
        .flag_long   (flag_long),
        .led_alarm   (led_alarm),
        .ringing     (ringing),
        .snoozed     (snoozed),
        .remain_s    (remain_s)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(input logic r, input logic s, input logic l, input int rem);
        obs_t v;
        v.ringing = r;
        v.snoozed = s;
        v.led     = l;
        v.remain  = 9'(rem);
        return v;
    endfunction

    // One clock of stimulus: queue the expectation, clock, capture outputs 1 time unit later
    task automatic cyc(input logic tk, input logic fs, input logic fl, input obs_t e, input string nm);
        obs_t o;
        tick_1hz   = tk;
        flag_short = fs;
        flag_long  = fl;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
        o.ringing = ringing;
        o.snoozed = snoozed;
        o.led     = led_alarm;
        o.remain  = remain_s;
        obs_q.push_back(o);
        tick_1hz   = 1'b0;
        flag_short = 1'b0;
        flag_long  = 1'b0;
    endtask

    task automatic start_ring(input string nm);
        alarm_match = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, mk(1, 0, 1, 60), nm);
        alarm_match = 1'b0;
    endtask

    task automatic snooze_expire(input string nm);
        for (int i = 1; i < 300; i++) cyc(1'b1, 1'b0, 1'b0, mk(0, 1, 0, 300 - i), nm);
        cyc(1'b1, 1'b0, 1'b0, mk(1, 0, 1, 60), {nm, "_expire"});
    endtask

    task automatic test_reset();
        obs_t e, o;
        string nm;
        reset = 1'b1; alarm_en = 1'b1; alarm_match = 1'b1;
        tick_1hz = 1'b0; flag_short = 1'b0; flag_long = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0), "reset_state");
        cyc(1'b1, 1'b1, 1'b0, mk(0, 0, 0, 0), "reset_ignores_inputs");
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0), "release_match_high");
        cyc(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0), "match_held_no_ring");
        alarm_match = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0), "match_low_idle");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL %s: got r=%0b s=%0b led=%0b rem=%0d, expected r=%0b s=%0b led=%0b rem=%0d",
                                  nm, o.ringing, o.snoozed, o.led, o.remain, e.ringing, e.snoozed, e.led, e.remain);
            else n_pass++;
        end
    endtask

    task automatic test_ring_timeout();
        obs_t  e, o;
        string nm;
        int    toggles = 0;
        logic  prev_ring = 1'b0, prev_led = 1'b0;
        start_ring("trig_ring");
        cyc(1'b0, 1'b0, 1'b0, mk(1, 0, 1, 60), "ring_hold");
        for (int i = 1; i < 60; i++) cyc(1'b1, 1'b0, 1'b0, mk(1, 0, (i % 2) == 0, 60 - i), "ring_tick");
        cyc(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0), "auto_stop");
        cyc(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0), "idle_tick_holds_zero");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            if (prev_ring && o.ringing && (o.led !== prev_led)) toggles++;
            prev_ring = o.ringing;
            prev_led  = o.led;
            n_checks++;
            if (o !== e) $display("FAIL %s: got r=%0b s=%0b led=%0b rem=%0d, expected r=%0b s=%0b led=%0b rem=%0d",
                                  nm, o.ringing, o.snoozed, o.led, o.remain, e.ringing, e.snoozed, e.led, e.remain);
            else n_pass++;
        end
        n_checks++;
        if (toggles != 59) $display("FAIL led_toggle_count: got %0d, expected 59", toggles);
        else n_pass++;
    endtask

    task automatic test_snooze();
        obs_t e, o;
        string nm;
        start_ring("trig_ring");
        cyc(1'b1, 1'b0, 1'b0, mk(1, 0, 0, 59), "ring_tick");
        alarm_match = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, mk(1, 0, 0, 59), "retrig_in_ring_ignored");
        alarm_match = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, mk(0, 1, 0, 300), "short_to_snooze");
        cyc(1'b0, 1'b1, 1'b0, mk(0, 1, 0, 300), "short_in_snooze_ignored");
        snooze_expire("snooze_tick");
        cyc(1'b1, 1'b0, 1'b0, mk(1, 0, 0, 59), "reloaded_ring_tick");
        cyc(1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0), "long_stops_ring");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL %s: got r=%0b s=%0b led=%0b rem=%0d, expected r=%0b s=%0b led=%0b rem=%0d",
                                  nm, o.ringing, o.snoozed, o.led, o.remain, e.ringing, e.snoozed, e.led, e.remain);
            else n_pass++;
        end
    endtask

    task automatic test_priority();
        obs_t e, o;
        string nm;
        start_ring("trig_ring");
        cyc(1'b0, 1'b1, 1'b1, mk(0, 0, 0, 0), "long_beats_short");
        start_ring("trig_ring2");
        cyc(1'b1, 1'b0, 1'b0, mk(1, 0, 0, 59), "ring_tick");
        cyc(1'b1, 1'b1, 1'b0, mk(0, 1, 0, 300), "short_beats_tick");
        cyc(1'b1, 1'b0, 1'b0, mk(0, 1, 0, 299), "snooze_tick");
        cyc(1'b1, 1'b0, 1'b1, mk(0, 0, 0, 0), "long_beats_tick_in_snooze");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL %s: got r=%0b s=%0b led=%0b rem=%0d, expected r=%0b s=%0b led=%0b rem=%0d",
                                  nm, o.ringing, o.snoozed, o.led, o.remain, e.ringing, e.snoozed, e.led, e.remain);
            else n_pass++;
        end
    endtask

    task automatic test_alarm_en();
        obs_t e, o;
        string nm;
        start_ring("trig_ring");
        cyc(1'b0, 1'b1, 1'b0, mk(0, 1, 0, 300), "short_to_snooze");
        cyc(1'b1, 1'b0, 1'b0, mk(0, 1, 0, 299), "snooze_tick");
        alarm_en = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0), "disarm_mid_snooze");
        alarm_match = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0), "match_while_disarmed");
        alarm_en = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0), "arm_with_match_high");
        alarm_match = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0), "match_low_idle");
        start_ring("trig_ring2");
        alarm_en = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0), "disarm_beats_short");
        alarm_en = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL %s: got r=%0b s=%0b led=%0b rem=%0d, expected r=%0b s=%0b led=%0b rem=%0d",
                                  nm, o.ringing, o.snoozed, o.led, o.remain, e.ringing, e.snoozed, e.led, e.remain);
            else n_pass++;
        end
    endtask

    task automatic test_reset_abort();
        obs_t e, o;
        string nm;
        start_ring("trig_ring");
        cyc(1'b1, 1'b0, 1'b0, mk(1, 0, 0, 59), "ring_tick");
        reset = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0), "reset_mid_ring");
        reset = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, mk(0, 0, 0, 0), "post_reset_idle");
        start_ring("trig_after_reset");
        cyc(1'b0, 1'b1, 1'b0, mk(0, 1, 0, 300), "short_to_snooze");
        reset = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0), "reset_mid_snooze");
        reset = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, mk(0, 0, 0, 0), "post_reset_tick_idle");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL %s: got r=%0b s=%0b led=%0b rem=%0d, expected r=%0b s=%0b led=%0b rem=%0d",
                                  nm, o.ringing, o.snoozed, o.led, o.remain, e.ringing, e.snoozed, e.led, e.remain);
            else n_pass++;
        end
    endtask

    task automatic test_snooze_limit();
        obs_t e, o;
        string nm;
        start_ring("trig_ring");
        for (int k = 1; k <= 3; k++) begin
            cyc(1'b0, 1'b1, 1'b0, mk(0, 1, 0, 300), $sformatf("snooze_%0d", k));
            snooze_expire($sformatf("snooze_%0d_tick", k));
        end
`ifdef ALARM_SNOOZE_LIMIT_EN
        cyc(1'b0, 1'b1, 1'b0, mk(0, 0, 0, 0), "fourth_short_stops");
        start_ring("trig_after_limit");
        cyc(1'b0, 1'b1, 1'b0, mk(0, 1, 0, 300), "count_cleared_snooze_ok");
`else
        cyc(1'b0, 1'b1, 1'b0, mk(0, 1, 0, 300), "fourth_short_snoozes");
`endif
        cyc(1'b0, 1'b0, 1'b1, mk(0, 0, 0, 0), "long_stops_snooze");
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); nm = name_q.pop_front();
            n_checks++;
            if (o !== e) $display("FAIL %s: got r=%0b s=%0b led=%0b rem=%0d, expected r=%0b s=%0b led=%0b rem=%0d",
                                  nm, o.ringing, o.snoozed, o.led, o.remain, e.ringing, e.snoozed, e.led, e.remain);
            else n_pass++;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached before the summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_ring_timeout();
        test_snooze();
        test_priority();
        test_alarm_en();
        test_reset_abort();
        test_snooze_limit();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
